vc_input_buffer: RTL and testbench

- Per-link input stage of the chiplet switch: receives flits from one upstream link and steers each into one of NUM_VCS per-VC FIFOs of DEPTH flits.
- Generalises the per-link buffer_available / credit_granted contract to arbitrary VC count and depth.
- Adds explicit per-VC credit return, selectable cut-through or store-and-forward, and error flags.
- Sits between the link receiver and the switch allocator/crossbar; one instance per NUM_BUFFERS input.

---
 rtl/chiplet_types_pkg.sv | 22 ++
 rtl/vc_fifo.sv | 134 +++++++++++++
 rtl/vc_input_buffer.sv | 102 ++++++++++
 tb/tb_vc_input_buffer.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chiplet_types_pkg.sv
// -----------------------------------------------------------------------------
// chiplet_types_pkg
// Shared types for the chiplet switch datapath.
//   flit_t   : one link flit (FLIT_W bits)
//   vc_id_t  : virtual-channel index at the default VC count
//   vc_width : index width for a given VC count, never less than one bit
// -----------------------------------------------------------------------------
package chiplet_types_pkg;

    localparam int FLIT_W = 32;
    typedef logic [FLIT_W-1:0] flit_t;

    // Default VC index width, matching the default of two virtual channels.
    localparam int VC_W = 1;
    typedef logic [VC_W-1:0] vc_id_t;

    // A single VC still needs a one-bit index port.
    function automatic int vc_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vc_fifo.sv
// -----------------------------------------------------------------------------
// vc_fifo
// One virtual-channel FIFO of DEPTH flits. It keeps the flit storage,
// modulo-DEPTH pointers, an occupancy count, a count of resident packet tails,
// the store-and-forward drain flag and the registered "slot free" indication.
//   CLK, nRST   : clock, asynchronous active-low reset
//   i_push      : write i_flit/i_last at the tail (already qualified, never full)
//   i_pop       : advance the head (already qualified, never empty/ineligible)
//   o_full      : count == DEPTH
//   o_valid     : head is eligible for allocation
//   o_flit      : head flit, holds its last value when the FIFO empties
//   o_last      : head flit is a packet tail
//   o_avail     : registered (next count < DEPTH)
//   o_oversize  : one-cycle pulse when a store-and-forward packet fills the FIFO
// -----------------------------------------------------------------------------
module vc_fifo
    import chiplet_types_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter bit CUT_THROUGH = 1'b1
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  i_push,
    input  flit_t i_flit,
    input  logic  i_last,
    input  logic  i_pop,
    output logic  o_full,
    output logic  o_valid,
    output flit_t o_flit,
    output logic  o_last,
    output logic  o_avail,
    output logic  o_oversize
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    flit_t            r_mem      [DEPTH];
    logic             r_last_mem [DEPTH];

    logic [PTR_W-1:0] r_wr_ptr, w_wr_ptr_next;
    logic [PTR_W-1:0] r_rd_ptr, w_rd_ptr_next;
    logic [CNT_W-1:0] r_count,  w_count_next;
    logic [CNT_W-1:0] r_tails,  w_tails_next;
    logic             r_drain,  w_drain_next;
    flit_t            r_head_flit, w_head_flit_next;
    logic             r_head_last, w_head_last_next;
    logic             r_avail;
    logic             w_oversize;
    logic             w_head_is_new;

    // Pointers wrap at DEPTH-1, so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_MAX) ? '0 : p + 1'b1;
    endfunction

    // A packet that fills the FIFO without its tail can never become eligible
    // in store-and-forward mode; drain lets it through as cut-through.
    assign w_oversize = !CUT_THROUGH && (r_count == CNT_FULL) &&
                        (r_tails == '0) && !r_drain;

    // The flit being pushed becomes the head when nothing else remains.
    assign w_head_is_new = (r_count == '0) || ((r_count == CNT_W'(1)) && i_pop);

    always_comb begin
        w_wr_ptr_next    = i_push ? ptr_inc(r_wr_ptr) : r_wr_ptr;
        w_rd_ptr_next    = i_pop  ? ptr_inc(r_rd_ptr) : r_rd_ptr;
        w_count_next     = r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        w_tails_next     = r_tails + CNT_W'(i_push && i_last)
                                   - CNT_W'(i_pop && r_head_last);
        w_drain_next     = r_drain;
        w_head_flit_next = r_head_flit;
        w_head_last_next = r_head_last;

        if (i_pop && r_head_last) begin
            w_drain_next = 1'b0;
        end
        if (w_oversize) begin
            w_drain_next = 1'b1;
        end

        // Head is kept in a register so an emptied FIFO holds its last flit.
        if (w_count_next != '0) begin
            if (w_head_is_new) begin
                w_head_flit_next = i_flit;
                w_head_last_next = i_last;
            end else begin
                w_head_flit_next = r_mem[w_rd_ptr_next];
                w_head_last_next = r_last_mem[w_rd_ptr_next];
            end
        end
    end

    // Storage carries no reset; only the count decides what is resident.
    always_ff @(posedge CLK) begin
        if (i_push) begin
            r_mem[r_wr_ptr]      <= i_flit;
            r_last_mem[r_wr_ptr] <= i_last;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_tails     <= '0;
            r_drain     <= 1'b0;
            r_head_flit <= '0;
            r_head_last <= 1'b0;
            r_avail     <= 1'b1;
        end else begin
            r_wr_ptr    <= w_wr_ptr_next;
            r_rd_ptr    <= w_rd_ptr_next;
            r_count     <= w_count_next;
            r_tails     <= w_tails_next;
            r_drain     <= w_drain_next;
            r_head_flit <= w_head_flit_next;
            r_head_last <= w_head_last_next;
            r_avail     <= (w_count_next < CNT_FULL);
        end
    end

    assign o_full     = (r_count == CNT_FULL);
    assign o_valid    = (r_count != '0) && (CUT_THROUGH || (r_tails != '0) || r_drain);
    assign o_flit     = r_head_flit;
    assign o_last     = r_head_last;
    assign o_avail    = r_avail;
    assign o_oversize = w_oversize;

endmodule

// File: rtl/vc_input_buffer.sv
// -----------------------------------------------------------------------------
// vc_input_buffer
// Per-link input stage: steers incoming flits into NUM_VCS per-VC FIFOs,
// returns one credit per dequeued flit and raises sticky error flags.
//   CLK, nRST        : clock, asynchronous active-low reset
//   in_flit/in_last  : incoming flit and its tail marker
//   data_ready_in    : incoming flit valid
//   in_vc            : target virtual channel
//   buffer_available : per-VC registered "slot free"
//   credit_granted   : per-VC one-cycle pulse, the cycle after a pop
//   out_flit/out_last/out_valid : per-VC head flit, tail marker, eligibility
//   out_pop          : per-VC dequeue request
//   overflow_err     : sticky, push to a full VC or to a nonexistent VC
//   underflow_err    : sticky, pop of an ineligible VC
//   oversize_err     : sticky, store-and-forward packet larger than DEPTH
// -----------------------------------------------------------------------------
module vc_input_buffer
    import chiplet_types_pkg::*;
#(
    parameter int NUM_VCS     = 2,
    parameter int DEPTH       = 4,
    parameter bit CUT_THROUGH = 1'b1
) (
    input  logic                          CLK,
    input  logic                          nRST,
    input  flit_t                         in_flit,
    input  logic                          data_ready_in,
    input  logic [vc_width(NUM_VCS)-1:0]  in_vc,
    input  logic                          in_last,
    output logic [NUM_VCS-1:0]            buffer_available,
    output logic [NUM_VCS-1:0]            credit_granted,
    output flit_t [NUM_VCS-1:0]           out_flit,
    output logic [NUM_VCS-1:0]            out_last,
    output logic [NUM_VCS-1:0]            out_valid,
    input  logic [NUM_VCS-1:0]            out_pop,
    output logic                          overflow_err,
    output logic                          underflow_err,
    output logic                          oversize_err
);

    localparam int IN_VC_W = vc_width(NUM_VCS);

    logic [NUM_VCS-1:0] w_push;
    logic [NUM_VCS-1:0] w_pop;
    logic [NUM_VCS-1:0] w_full;
    logic [NUM_VCS-1:0] w_oversize;
    logic               w_drop;
    logic               w_bad_pop;

    logic [NUM_VCS-1:0] r_credit;
    logic               r_overflow;
    logic               r_underflow;
    logic               r_oversize;

    for (genvar gi = 0; gi < NUM_VCS; gi++) begin : g_vc
        // A full VC refuses the push even if it pops this same cycle.
        assign w_push[gi] = data_ready_in && (in_vc == IN_VC_W'(gi)) && !w_full[gi];
        assign w_pop[gi]  = out_pop[gi] && out_valid[gi];

        vc_fifo #(
            .DEPTH       (DEPTH),
            .CUT_THROUGH (CUT_THROUGH)
        ) u_fifo (
            .CLK        (CLK),
            .nRST       (nRST),
            .i_push     (w_push[gi]),
            .i_flit     (in_flit),
            .i_last     (in_last),
            .i_pop      (w_pop[gi]),
            .o_full     (w_full[gi]),
            .o_valid    (out_valid[gi]),
            .o_flit     (out_flit[gi]),
            .o_last     (out_last[gi]),
            .o_avail    (buffer_available[gi]),
            .o_oversize (w_oversize[gi])
        );
    end

    // Any valid flit that no VC accepted was either full or out of range.
    assign w_drop    = data_ready_in && (w_push == '0);
    assign w_bad_pop = |(out_pop & ~out_valid);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_credit    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_oversize  <= 1'b0;
        end else begin
            r_credit    <= w_pop;
            r_overflow  <= r_overflow  | w_drop;
            r_underflow <= r_underflow | w_bad_pop;
            r_oversize  <= r_oversize  | (|w_oversize);
        end
    end

    assign credit_granted = r_credit;
    assign overflow_err   = r_overflow;
    assign underflow_err  = r_underflow;
    assign oversize_err   = r_oversize;

endmodule

// File: tb/tb_vc_input_buffer.sv
module tb_vc_input_buffer;
    import chiplet_types_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic  rst_n;
    flit_t in_flit;
    logic  in_last;

    // Instance A: 2 VCs, depth 4, cut-through
    logic        dri_a;
    logic [0:0]  vc_a;
    logic [1:0]  opop_a;
    logic [1:0]  avail_a, credit_a, olast_a, ovalid_a;
    flit_t [1:0] oflit_a;
    logic        ovf_a, unf_a, osz_a;

    // Instance B: 2 VCs, depth 4, store-and-forward
    logic        dri_b;
    logic [0:0]  vc_b;
    logic [1:0]  opop_b;
    logic [1:0]  avail_b, credit_b, olast_b, ovalid_b;
    flit_t [1:0] oflit_b;
    logic        ovf_b, unf_b, osz_b;

    // Instance C: 3 VCs, depth 3, cut-through
    logic        dri_c;
    logic [1:0]  vc_c;
    logic [2:0]  opop_c;
    logic [2:0]  avail_c, credit_c, olast_c, ovalid_c;
    flit_t [2:0] oflit_c;
    logic        ovf_c, unf_c, osz_c;

    int n_vec = 0;
    int n_err = 0;

    logic [FLIT_W:0] sb_a [2][$];
    logic [FLIT_W:0] sb_b [$];
    logic [FLIT_W:0] sb_c [$];

    vc_input_buffer #(.NUM_VCS(2), .DEPTH(4), .CUT_THROUGH(1'b1)) dut_a (
        .CLK(clk), .nRST(rst_n), .in_flit(in_flit), .data_ready_in(dri_a),
        .in_vc(vc_a), .in_last(in_last), .buffer_available(avail_a),
        .credit_granted(credit_a), .out_flit(oflit_a), .out_last(olast_a),
        .out_valid(ovalid_a), .out_pop(opop_a), .overflow_err(ovf_a),
        .underflow_err(unf_a), .oversize_err(osz_a));

    vc_input_buffer #(.NUM_VCS(2), .DEPTH(4), .CUT_THROUGH(1'b0)) dut_b (
        .CLK(clk), .nRST(rst_n), .in_flit(in_flit), .data_ready_in(dri_b),
        .in_vc(vc_b), .in_last(in_last), .buffer_available(avail_b),
        .credit_granted(credit_b), .out_flit(oflit_b), .out_last(olast_b),
        .out_valid(ovalid_b), .out_pop(opop_b), .overflow_err(ovf_b),
        .underflow_err(unf_b), .oversize_err(osz_b));

    vc_input_buffer #(.NUM_VCS(3), .DEPTH(3), .CUT_THROUGH(1'b1)) dut_c (
        .CLK(clk), .nRST(rst_n), .in_flit(in_flit), .data_ready_in(dri_c),
        .in_vc(vc_c), .in_last(in_last), .buffer_available(avail_c),
        .credit_granted(credit_c), .out_flit(oflit_c), .out_last(olast_c),
        .out_valid(ovalid_c), .out_pop(opop_c), .overflow_err(ovf_c),
        .underflow_err(unf_c), .oversize_err(osz_c));

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_push_a(input int vc, input flit_t f, input logic last, input bit accept);
        dri_a = 1'b1; vc_a = 1'(vc); in_flit = f; in_last = last;
        if (accept) sb_a[vc].push_back({last, f});
        step();
        dri_a = 1'b0; in_last = 1'b0;
        $display("A push vc%0d flit=%h last=%0b expect_accept=%0b", vc, f, last, accept);
    endtask

    task automatic do_pop_a(input int vc);
        logic [FLIT_W:0] exp;
        exp = sb_a[vc].pop_front();
        n_vec++;
        if ({olast_a[vc], oflit_a[vc]} !== exp || ovalid_a[vc] !== 1'b1) begin
            n_err++;
            $display("FAIL a_head vc%0d got last=%0b flit=%h valid=%0b want %h valid=1",
                     vc, olast_a[vc], oflit_a[vc], ovalid_a[vc], exp);
        end
        opop_a[vc] = 1'b1;
        step();
        opop_a = '0;
        n_vec++;
        if (credit_a !== (2'b01 << vc)) begin
            n_err++;
            $display("FAIL a_credit vc%0d got %b want %b", vc, credit_a, 2'b01 << vc);
        end
        $display("A pop vc%0d flit=%h", vc, exp[FLIT_W-1:0]);
    endtask

    task automatic do_push_b(input flit_t f, input logic last);
        dri_b = 1'b1; vc_b = 1'b0; in_flit = f; in_last = last;
        sb_b.push_back({last, f});
        step();
        dri_b = 1'b0; in_last = 1'b0;
        $display("B push vc0 flit=%h last=%0b", f, last);
    endtask

    task automatic do_pop_b();
        logic [FLIT_W:0] exp;
        exp = sb_b.pop_front();
        n_vec++;
        if ({olast_b[0], oflit_b[0]} !== exp || ovalid_b[0] !== 1'b1) begin
            n_err++;
            $display("FAIL b_head got last=%0b flit=%h valid=%0b want %h valid=1",
                     olast_b[0], oflit_b[0], ovalid_b[0], exp);
        end
        opop_b[0] = 1'b1;
        step();
        opop_b = '0;
        n_vec++;
        if (credit_b !== 2'b01) begin
            n_err++;
            $display("FAIL b_credit got %b want 01", credit_b);
        end
        $display("B pop vc0 flit=%h", exp[FLIT_W-1:0]);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        for (int v = 0; v < 2; v++) sb_a[v].delete();
        sb_b.delete(); sb_c.delete();
        n_vec++;
        if (avail_a !== 2'b11 || credit_a !== 2'b00 || ovalid_a !== 2'b00 ||
            olast_a !== 2'b00 || oflit_a !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got avail=%b credit=%b valid=%b last=%b flit=%h want 11 00 00 00 0",
                     avail_a, credit_a, ovalid_a, olast_a, oflit_a);
        end
        n_vec++;
        if ({ovf_a, unf_a, osz_a, ovf_b, unf_b, osz_b, ovf_c, unf_c, osz_c} !== 9'b0) begin
            n_err++;
            $display("FAIL reset_errors got %b%b%b want 000", ovf_a, unf_a, osz_a);
        end
        n_vec++;
        if (avail_b !== 2'b11 || avail_c !== 3'b111 || ovalid_c !== 3'b000) begin
            n_err++;
            $display("FAIL reset_other got avail_b=%b avail_c=%b valid_c=%b want 11 111 000",
                     avail_b, avail_c, ovalid_c);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_cut_through();
        for (int i = 0; i < 3; i++) begin
            do_push_a(1, flit_t'(32'hA100 + i), (i == 2), 1'b1);
            n_vec++;
            if (ovalid_a[1] !== 1'b1 || avail_a[1] !== 1'b1) begin
                n_err++;
                $display("FAIL ct_push%0d got valid=%0b avail=%0b want 1 1", i, ovalid_a[1], avail_a[1]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            do_pop_a(1);
            n_vec++;
            if (avail_a[1] !== 1'b1) begin
                n_err++;
                $display("FAIL ct_avail%0d got %0b want 1", i, avail_a[1]);
            end
            step();
            n_vec++;
            if (credit_a !== 2'b00) begin
                n_err++;
                $display("FAIL ct_credit_end%0d got %b want 00", i, credit_a);
            end
        end
        n_vec++;
        if (ovalid_a !== 2'b00 || ovf_a !== 1'b0) begin
            n_err++;
            $display("FAIL ct_empty got valid=%b ovf=%0b want 00 0", ovalid_a, ovf_a);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) begin
            do_push_a(0, flit_t'(32'hB000 + i), 1'b0, 1'b1);
            n_vec++;
            if (avail_a[0] !== (i < 3)) begin
                n_err++;
                $display("FAIL ovf_avail%0d got %0b want %0b", i, avail_a[0], (i < 3));
            end
        end
        do_push_a(0, flit_t'(32'hDEAD), 1'b1, 1'b0);
        n_vec++;
        if (ovf_a !== 1'b1 || avail_a[0] !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_drop got ovf=%0b avail=%0b want 1 0", ovf_a, avail_a[0]);
        end
        do_pop_a(0);
        n_vec++;
        if (avail_a[0] !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_avail_after_pop got %0b want 1", avail_a[0]);
        end
        for (int i = 0; i < 3; i++) do_pop_a(0);
        n_vec++;
        if (ovalid_a[0] !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_count4 got valid=%0b want 0", ovalid_a[0]);
        end
    endtask

    task automatic test_simultaneous();
        logic [FLIT_W:0] exp0, exp1;
        do_push_a(0, flit_t'(32'hC000), 1'b0, 1'b1);
        do_push_a(0, flit_t'(32'hC001), 1'b0, 1'b1);
        // push and pop on VC0 in the same cycle
        exp0 = sb_a[0].pop_front();
        n_vec++;
        if ({olast_a[0], oflit_a[0]} !== exp0) begin
            n_err++;
            $display("FAIL sim_head got %h want %h", {olast_a[0], oflit_a[0]}, exp0);
        end
        dri_a = 1'b1; vc_a = 1'b0; in_flit = flit_t'(32'hC002); in_last = 1'b1;
        opop_a = 2'b01;
        sb_a[0].push_back({1'b1, flit_t'(32'hC002)});
        step();
        dri_a = 1'b0; in_last = 1'b0; opop_a = '0;
        $display("A push+pop vc0 push=C002 pop=%h", exp0[FLIT_W-1:0]);
        n_vec++;
        if (credit_a !== 2'b01 || avail_a[0] !== 1'b1) begin
            n_err++;
            $display("FAIL sim_credit got credit=%b avail=%0b want 01 1", credit_a, avail_a[0]);
        end
        do_pop_a(0);
        do_pop_a(0);
        n_vec++;
        if (ovalid_a[0] !== 1'b0) begin
            n_err++;
            $display("FAIL sim_count2 got valid=%0b want 0", ovalid_a[0]);
        end
        // independent pops on both VCs
        do_push_a(0, flit_t'(32'hD000), 1'b1, 1'b1);
        do_push_a(1, flit_t'(32'hD001), 1'b1, 1'b1);
        exp0 = sb_a[0].pop_front();
        exp1 = sb_a[1].pop_front();
        n_vec++;
        if ({olast_a[0], oflit_a[0]} !== exp0 || {olast_a[1], oflit_a[1]} !== exp1) begin
            n_err++;
            $display("FAIL dual_heads got %h %h want %h %h",
                     {olast_a[0], oflit_a[0]}, {olast_a[1], oflit_a[1]}, exp0, exp1);
        end
        opop_a = 2'b11;
        step();
        opop_a = '0;
        $display("A pop vc0 and vc1 together");
        n_vec++;
        if (credit_a !== 2'b11) begin
            n_err++;
            $display("FAIL dual_credit got %b want 11", credit_a);
        end
        step();
        n_vec++;
        if (credit_a !== 2'b00 || ovalid_a !== 2'b00) begin
            n_err++;
            $display("FAIL dual_after got credit=%b valid=%b want 00 00", credit_a, ovalid_a);
        end
        // pop of an empty VC
        opop_a = 2'b10;
        step();
        opop_a = '0;
        $display("A pop vc1 while empty");
        n_vec++;
        if (unf_a !== 1'b1 || credit_a !== 2'b00) begin
            n_err++;
            $display("FAIL underflow got unf=%0b credit=%b want 1 00", unf_a, credit_a);
        end
    endtask

    task automatic test_store_forward();
        do_push_b(flit_t'(32'hE000), 1'b0);
        do_push_b(flit_t'(32'hE001), 1'b0);
        n_vec++;
        if (ovalid_b[0] !== 1'b0) begin
            n_err++;
            $display("FAIL sf_wait got valid=%0b want 0", ovalid_b[0]);
        end
        do_push_b(flit_t'(32'hE002), 1'b1);
        n_vec++;
        if (ovalid_b[0] !== 1'b1) begin
            n_err++;
            $display("FAIL sf_tail got valid=%0b want 1", ovalid_b[0]);
        end
        for (int i = 0; i < 3; i++) do_pop_b();
        // oversize packet: four bodies fill the VC with no tail
        for (int i = 0; i < 4; i++) do_push_b(flit_t'(32'hF000 + i), 1'b0);
        n_vec++;
        if (ovalid_b[0] !== 1'b0 || osz_b !== 1'b0) begin
            n_err++;
            $display("FAIL os_before got valid=%0b osz=%0b want 0 0", ovalid_b[0], osz_b);
        end
        step();
        n_vec++;
        if (ovalid_b[0] !== 1'b1 || osz_b !== 1'b1) begin
            n_err++;
            $display("FAIL os_drain got valid=%0b osz=%0b want 1 1", ovalid_b[0], osz_b);
        end
        do_pop_b();
        do_push_b(flit_t'(32'hF0FF), 1'b1);
        for (int i = 0; i < 4; i++) do_pop_b();
        // drain ends with the tail, so a new headless packet waits again
        do_push_b(flit_t'(32'hF100), 1'b0);
        n_vec++;
        if (ovalid_b[0] !== 1'b0 || ovf_b !== 1'b0) begin
            n_err++;
            $display("FAIL os_cleared got valid=%0b ovf=%0b want 0 0", ovalid_b[0], ovf_b);
        end
    endtask

    task automatic test_wrap_invalid();
        logic [FLIT_W:0] exp;
        dri_c = 1'b1; vc_c = 2'd3; in_flit = flit_t'(32'h0BAD);
        step();
        dri_c = 1'b0;
        $display("C push vc3 flit=0bad (no such VC)");
        n_vec++;
        if (ovf_c !== 1'b1 || ovalid_c !== 3'b000) begin
            n_err++;
            $display("FAIL bad_vc got ovf=%0b valid=%b want 1 000", ovf_c, ovalid_c);
        end
        for (int i = 0; i < 11; i++) begin
            if (i > 0) begin
                exp = sb_c.pop_front();
                n_vec++;
                if ({olast_c[1], oflit_c[1]} !== exp || ovalid_c[1] !== 1'b1) begin
                    n_err++;
                    $display("FAIL wrap%0d got %h valid=%0b want %h valid=1",
                             i, {olast_c[1], oflit_c[1]}, ovalid_c[1], exp);
                end
                opop_c = 3'b010;
            end
            if (i < 10) begin
                dri_c = 1'b1; vc_c = 2'd1; in_flit = flit_t'(32'hC100 + i); in_last = (i == 9);
                sb_c.push_back({in_last, in_flit});
            end
            step();
            dri_c = 1'b0; in_last = 1'b0; opop_c = '0;
            $display("C cycle %0d push=%0b pop=%0b", i, (i < 10), (i > 0));
        end
        n_vec++;
        if (ovalid_c !== 3'b000 || unf_c !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_end got valid=%b unf=%0b want 000 0", ovalid_c, unf_c);
        end
    endtask

    task automatic test_reset_mid();
        do_push_a(0, flit_t'(32'h5000), 1'b0, 1'b1);
        do_push_a(0, flit_t'(32'h5001), 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        $display("A reset asserted with 2 flits buffered");
        n_vec++;
        if (ovalid_a !== 2'b00 || avail_a !== 2'b11 || oflit_a !== '0 || olast_a !== 2'b00) begin
            n_err++;
            $display("FAIL rst_mid_out got valid=%b avail=%b flit=%h last=%b want 00 11 0 00",
                     ovalid_a, avail_a, oflit_a, olast_a);
        end
        n_vec++;
        if (ovf_a !== 1'b0 || unf_a !== 1'b0 || credit_a !== 2'b00) begin
            n_err++;
            $display("FAIL rst_mid_err got ovf=%0b unf=%0b credit=%b want 0 0 00", ovf_a, unf_a, credit_a);
        end
        for (int v = 0; v < 2; v++) sb_a[v].delete();
        step(); step();
        rst_n = 1'b1;
        step(); step();
        n_vec++;
        if (credit_a !== 2'b00 || ovalid_a !== 2'b00) begin
            n_err++;
            $display("FAIL rst_mid_after got credit=%b valid=%b want 00 00", credit_a, ovalid_a);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_flit = '0; in_last = 1'b0;
        dri_a = 1'b0; vc_a = '0; opop_a = '0;
        dri_b = 1'b0; vc_b = '0; opop_b = '0;
        dri_c = 1'b0; vc_c = '0; opop_c = '0;
        step();
        test_reset();
        test_cut_through();
        test_overflow();
        test_simultaneous();
        test_store_forward();
        test_wrap_invalid();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
